// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the KxK convolution engine: the controller state
//   encoding, a constant-evaluable clog2, and the bounds of the legal
//   configuration space (K up to 7).
// ---------------------------------------------------------------------------
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_KERN = 3'd1,
      LD_WIN  = 3'd2,
      MAC     = 3'd3,
      WRITE   = 3'd4
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Largest kernel the engine is ever built with, and the counter width it needs.
   localparam int KK_MAX    = 49;
   localparam int IDX_W_MAX = clog2(KK_MAX + 1);

endpackage

// File: rtl/conv_mac_lane.sv
// ---------------------------------------------------------------------------
// conv_mac_lane
//   One output pixel of the convolution engine: unsigned multiply-accumulate,
//   then right-shift requantisation with unsigned saturation into a DW-bit
//   result register that holds until the next write.
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clr             zero the accumulator (start of a job)
//   i_en              accumulate i_win*i_kern this cycle
//   i_wr              load the saturated result into o_sum
//   i_win, i_kern     pixel and kernel operands (DW, unsigned)
//   i_shift           requantisation right shift
//   o_sum             registered saturated result
// ---------------------------------------------------------------------------
module conv_mac_lane #(
   parameter int DW    = 8,
   parameter int ACC_W = 24
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic          i_wr,
   input  logic [DW-1:0] i_win,
   input  logic [DW-1:0] i_kern,
   input  logic [4:0]    i_shift,
   output logic [DW-1:0] o_sum
);

   logic [ACC_W-1:0] acc_q;
   logic [2*DW-1:0]  prod;

   assign prod = i_win * i_kern;

   function automatic logic [DW-1:0] sat_shift(input logic [ACC_W-1:0] a,
                                               input logic [4:0]       sh);
      logic [ACC_W-1:0] s;
      s = a >> sh;
      if (s > ACC_W'({DW{1'b1}}))
         return {DW{1'b1}};
      return s[DW-1:0];
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_q <= '0;
         o_sum <= '0;
      end else begin
         if (i_clr)
            acc_q <= '0;
         else if (i_en)
            acc_q <= acc_q + ACC_W'(prod);
         if (i_wr)
            o_sum <= sat_shift(acc_q, i_shift);
      end
   end

endmodule

// File: rtl/conv2d_engine.sv
// ---------------------------------------------------------------------------
// conv2d_engine
//   KxK 2-D convolution over LANES horizontally strided windows. Loads the
//   kernel, then the windows, from a 1-cycle synchronous SRAM, runs LANES MACs
//   in parallel and writes saturated, right-shifted results.
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start          job request, sampled only when idle
//   i_src_base       address of window (0,0) for lane 0
//   i_kern_base      address of kernel (0,0), row-major
//   i_stride         lane-to-lane horizontal offset in words
//   i_shift          requantisation right shift
//   o_k_addr/i_k_data      kernel read port (data one cycle after address)
//   o_src_addr/i_src_data  per-lane source read ports, lane l at slice l
//   o_sum            per-lane saturated results, held until the next write
//   o_busy           high whenever a job is in progress
//   o_done           one-cycle pulse when o_sum has just been updated
// ---------------------------------------------------------------------------
module conv2d_engine
   import conv_pkg::*;
#(
   parameter int DW    = 8,
   parameter int AW    = 10,
   parameter int K     = 3,
   parameter int LANES = 2,
   parameter int IMG_W = 28,
   parameter int ACC_W = 24
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [AW-1:0]         i_src_base,
   input  logic [AW-1:0]         i_kern_base,
   input  logic [2:0]            i_stride,
   input  logic [4:0]            i_shift,
   output logic [AW-1:0]         o_k_addr,
   input  logic [DW-1:0]         i_k_data,
   output logic [LANES*AW-1:0]   o_src_addr,
   input  logic [LANES*DW-1:0]   i_src_data,
   output logic [LANES*DW-1:0]   o_sum,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int KK    = K * K;
   localparam int IDX_W = clog2(KK + 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q;
   logic [AW-1:0]    src_base_q, kern_base_q;
   logic [2:0]       stride_q;
   logic [4:0]       shift_q;
   logic             last_ld, last_mac;
   logic             lane_clr, lane_en, lane_wr;

   logic [DW-1:0]    kern_q [KK];
   logic [DW-1:0]    win_q  [LANES][KK];

   // Row-major element index -> offset inside the source image.
   function automatic logic [AW-1:0] win_off(input logic [IDX_W-1:0] n);
      int ni;
      ni = int'(n);
      return AW'((ni / K) * IMG_W + (ni % K));
   endfunction

   // Load phases run one extra cycle so the last read's data can land.
   assign last_ld  = (cnt_q == IDX_W'(KK));
   assign last_mac = (cnt_q == IDX_W'(KK - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      o_busy   = (state_q != IDLE);
      lane_clr = 1'b0;
      lane_en  = 1'b0;
      lane_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d  = LD_KERN;
               lane_clr = 1'b1;
            end
         end
         LD_KERN: if (last_ld) state_d = LD_WIN;
         LD_WIN:  if (last_ld) state_d = MAC;
         MAC: begin
            lane_en = 1'b1;
            if (last_mac) state_d = WRITE;
         end
         WRITE: begin
            lane_wr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q       <= '0;
         src_base_q  <= '0;
         kern_base_q <= '0;
         stride_q    <= '0;
         shift_q     <= '0;
         o_done      <= 1'b0;
      end else begin
         // o_done lines up with the cycle o_sum first shows the new result.
         o_done <= (state_q == WRITE);
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (i_start) begin
                  src_base_q  <= i_src_base;
                  kern_base_q <= i_kern_base;
                  stride_q    <= i_stride;
                  shift_q     <= i_shift;
               end
            end
            LD_KERN, LD_WIN: cnt_q <= last_ld  ? '0 : cnt_q + IDX_W'(1);
            MAC:             cnt_q <= last_mac ? '0 : cnt_q + IDX_W'(1);
            default:         cnt_q <= '0;
         endcase
      end
   end

   // Read data arrives one cycle after its address, hence index cnt-1.
   always_ff @(posedge i_clk) begin
      if (state_q == LD_KERN && cnt_q != '0)
         kern_q[cnt_q - IDX_W'(1)] <= i_k_data;
      if (state_q == LD_WIN && cnt_q != '0)
         for (int l = 0; l < LANES; l++)
            win_q[l][cnt_q - IDX_W'(1)] <= i_src_data[l*DW +: DW];
   end

   assign o_k_addr = kern_base_q + AW'(cnt_q);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign o_src_addr[l*AW +: AW] = src_base_q + win_off(cnt_q)
                                      + AW'(l) * AW'(stride_q);

      conv_mac_lane #(
         .DW    (DW),
         .ACC_W (ACC_W)
      ) u_lane (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_clr   (lane_clr),
         .i_en    (lane_en),
         .i_wr    (lane_wr),
         .i_win   (win_q[l][cnt_q]),
         .i_kern  (kern_q[cnt_q]),
         .i_shift (shift_q),
         .o_sum   (o_sum[l*DW +: DW])
      );
   end

endmodule
